// File: rtl/fetch_unit.sv
// Fetch-stage sequencer: owns the PC, reads the instruction memory combinationally,
// and feeds decode through a valid/ready IF/ID register. Supports redirects and a halt word.
//
// state | meaning
// WAIT  | post-reset delay while the instruction memory is preloaded
// FETCH | fetching one instruction per accepted cycle
// HALT  | halt word seen; idle until a redirect
module fetch_unit #(
  parameter int unsigned MEM_BYTES = 1000,
  parameter int unsigned START_CYC = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [31:0] DR,
  input  logic [31:0] INS,
  input  logic        BR_EN,
  input  logic [31:0] BR_TGT,
  input  logic        ID_RDY,
  output logic        ID_VAL,
  output logic [31:0] ID_INS,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic        HALTED
);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [31:0] LP_MEM  = 32'(MEM_BYTES);
  localparam logic [31:0] LP_LAST = 32'(START_CYC - 1);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_cnt;
  logic        r_id_val;
  logic [31:0] r_id_ins;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;

  logic [31:0] w_pc4;
  logic [31:0] w_nxt;
  logic [31:0] w_tgt_al;
  logic [31:0] w_tgt;
  logic        w_accept;
  logic        w_is_halt;

  assign w_pc4     = r_pc + 32'd4;
  assign w_nxt     = (w_pc4 >= LP_MEM) ? 32'd0 : w_pc4;
  // Targets are word-aligned first, then clamped to the memory range.
  assign w_tgt_al  = {BR_TGT[31:2], 2'b00};
  assign w_tgt     = (w_tgt_al >= LP_MEM) ? 32'd0 : w_tgt_al;
  assign w_accept  = !r_id_val || ID_RDY;
  assign w_is_halt = (INS == HALT_WORD);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= S_WAIT;
      r_pc     <= RESET_PC;
      r_cnt    <= 32'd0;
      r_id_val <= 1'b0;
      r_id_ins <= 32'd0;
      r_id_pc  <= 32'd0;
      r_id_pc4 <= 32'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (r_cnt == LP_LAST) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (BR_EN) begin
            r_pc     <= w_tgt;
            r_id_val <= 1'b0;
          end else if (w_accept) begin
            if (w_is_halt) begin
              r_id_val <= 1'b0;
              r_state  <= S_HALT;
            end else begin
              r_id_ins <= INS;
              r_id_pc  <= r_pc;
              r_id_pc4 <= w_nxt;
              r_id_val <= 1'b1;
              r_pc     <= w_nxt;
            end
          end
        end
        S_HALT: begin
          if (BR_EN) begin
            r_pc     <= w_tgt;
            r_id_val <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign DR     = r_pc;
  assign ID_VAL = r_id_val;
  assign ID_INS = r_id_ins;
  assign ID_PC  = r_id_pc;
  assign ID_PC4 = r_id_pc4;
  assign HALTED = (r_state == S_HALT);

endmodule
